router_fsm: RTL and testbench

ROUTER_FSM -- requirements
Module: router_fsm

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_fsm.sv | 96 +++++++++
 tb/tb_router_fsm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router FSM: state encoding and destination address constants.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ADDR0        = 2'd0;
    localparam logic [1:0] ADDR1        = 2'd1;
    localparam logic [1:0] ADDR2        = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    function automatic logic addr_valid(input logic [1:0] a);
        return (a == ADDR0) || (a == ADDR1) || (a == ADDR2);
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences header/payload/parity loads
// and stalls on full or non-empty output FIFOs.
module router_fsm
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       pktvalid,
    input  logic [1:0] datain,
    input  logic       fifofull,
    input  logic       fifoempty0,
    input  logic       fifoempty1,
    input  logic       fifoempty2,
    input  logic       softreset0,
    input  logic       softreset1,
    input  logic       softreset2,
    input  logic       paritydone,
    input  logic       lowpktvalid,
    output logic       writeenbreg,
    output logic       detectadd,
    output logic       lfdstate,
    output logic       ldstate,
    output logic       lafstate,
    output logic       fullstate,
    output logic       rstintreg,
    output logic       busy
);

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;

    // Bit 3 pads the invalid address so it never selects a channel.
    logic [3:0] empty_v;
    logic [3:0] srst_v;

    assign empty_v = {1'b0, fifoempty2, fifoempty1, fifoempty0};
    assign srst_v  = {1'b0, softreset2, softreset1, softreset0};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= ADDR0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (pktvalid && addr_valid(datain))
                    state_d = empty_v[datain] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_v[addr_q]) state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifofull)       state_d = FIFO_FULL_STATE;
                else if (!pktvalid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifofull) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (paritydone)       state_d = DECODE_ADDRESS;
                else if (lowpktvalid) state_d = LOAD_PARITY;
                else                  state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifofull ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default: state_d = DECODE_ADDRESS;
        endcase

        // Timeout on the channel being served aborts the packet from any state.
        if (srst_v[addr_q]) state_d = DECODE_ADDRESS;

        if (state_q == DECODE_ADDRESS && state_d != DECODE_ADDRESS) addr_d = datain;
    end

    always_comb begin
        detectadd   = (state_q == DECODE_ADDRESS);
        lfdstate    = (state_q == LOAD_FIRST_DATA);
        ldstate     = (state_q == LOAD_DATA);
        fullstate   = (state_q == FIFO_FULL_STATE);
        lafstate    = (state_q == LOAD_AFTER_FULL);
        rstintreg   = (state_q == CHECK_PARITY_ERROR);
        writeenbreg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL) ||
                      (state_q == LOAD_PARITY);
        busy        = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: a table of per-cycle inputs and expected Moore outputs.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       resetn, pktvalid, fifofull, paritydone, lowpktvalid;
    logic [1:0] datain;
    logic       fifoempty0, fifoempty1, fifoempty2;
    logic       softreset0, softreset1, softreset2;
    logic       writeenbreg, detectadd, lfdstate, ldstate, lafstate, fullstate, rstintreg, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    router_fsm dut (
        .clk(clk), .resetn(resetn), .pktvalid(pktvalid), .datain(datain),
        .fifofull(fifofull), .fifoempty0(fifoempty0), .fifoempty1(fifoempty1),
        .fifoempty2(fifoempty2), .softreset0(softreset0), .softreset1(softreset1),
        .softreset2(softreset2), .paritydone(paritydone), .lowpktvalid(lowpktvalid),
        .writeenbreg(writeenbreg), .detectadd(detectadd), .lfdstate(lfdstate),
        .ldstate(ldstate), .lafstate(lafstate), .fullstate(fullstate),
        .rstintreg(rstintreg), .busy(busy)
    );

    // Output bits: {writeenbreg, detectadd, lfdstate, ldstate, lafstate, fullstate, rstintreg, busy}
    localparam logic [7:0] O_DA  = 8'b0100_0000;
    localparam logic [7:0] O_LFD = 8'b0010_0001;
    localparam logic [7:0] O_LD  = 8'b1001_0000;
    localparam logic [7:0] O_WTE = 8'b0000_0001;
    localparam logic [7:0] O_FUL = 8'b0000_0101;
    localparam logic [7:0] O_LAF = 8'b1000_1001;
    localparam logic [7:0] O_LP  = 8'b1000_0001;
    localparam logic [7:0] O_CPE = 8'b0000_0011;

    typedef struct {
        logic       rn;
        logic       pv;
        logic [1:0] d;
        logic       ff;
        logic [2:0] fe;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] outs();
        return {writeenbreg, detectadd, lfdstate, ldstate, lafstate, fullstate, rstintreg, busy};
    endfunction

    task automatic add(input logic rn, input logic pv, input logic [1:0] d, input logic ff,
                       input logic [2:0] fe, input logic [2:0] sr, input logic pd,
                       input logic lpv, input logic [7:0] exp);
        vec_t v;
        v.rn = rn; v.pv = pv; v.d = d; v.ff = ff; v.fe = fe; v.sr = sr;
        v.pd = pd; v.lpv = lpv; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        resetn = v.rn; pktvalid = v.pv; datain = v.d; fifofull = v.ff;
        {fifoempty2, fifoempty1, fifoempty0} = v.fe;
        {softreset2, softreset1, softreset0} = v.sr;
        paritydone = v.pd; lowpktvalid = v.lpv;
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        checks++;
        if (outs() !== exp) begin
            failures++;
            $display("FAIL %s: outputs=%b required=%b", name, outs(), exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled 1ns after the next edge.
    task automatic step(input vec_t v, input string name);
        drive(v);
        @(posedge clk);
        #1;
        check(name, v.exp);
    endtask

    initial begin
        vec_t v;
        //   rn pv d     ff fe      sr      pd lpv exp
        add(0, 1, 2'd1, 1, 3'b111, 3'b000, 0, 0, O_DA);   // reset
        // addr 1 normal packet
        add(1, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LFD);
        add(1, 1, 2'd1, 0, 3'b010, 3'b000, 0, 0, O_LD);
        add(1, 1, 2'd3, 0, 3'b000, 3'b000, 0, 0, O_LD);
        add(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LP);
        add(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_CPE);
        add(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_DA);
        // addr 0, full for 3 cycles, then low pktvalid ends the packet
        add(1, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LFD);
        add(1, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LD);
        add(1, 0, 2'd0, 1, 3'b000, 3'b000, 0, 0, O_FUL);  // fifofull beats !pktvalid
        add(1, 1, 2'd0, 1, 3'b000, 3'b000, 0, 0, O_FUL);
        add(1, 1, 2'd0, 1, 3'b000, 3'b000, 0, 0, O_FUL);
        add(1, 1, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LAF);
        add(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 1, O_LP);
        add(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_CPE);
        add(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_DA);
        // addr 0, full then paritydone; also LAF falling back to LD
        add(1, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LFD);
        add(1, 1, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LD);
        add(1, 1, 2'd0, 1, 3'b000, 3'b000, 0, 0, O_FUL);
        add(1, 1, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LAF);
        add(1, 1, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LD);
        add(1, 1, 2'd0, 1, 3'b000, 3'b000, 0, 0, O_FUL);
        add(1, 1, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LAF);
        add(1, 1, 2'd0, 0, 3'b000, 3'b000, 1, 1, O_DA);   // paritydone beats lowpktvalid
        // addr 2 waits for empty; datain/other empties ignored while waiting
        add(1, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0, O_WTE);
        add(1, 1, 2'd0, 0, 3'b011, 3'b000, 0, 0, O_WTE);
        add(1, 1, 2'd0, 0, 3'b100, 3'b000, 0, 0, O_LFD);
        add(1, 1, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LD);
        add(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LP);
        add(1, 0, 2'd0, 1, 3'b000, 3'b000, 0, 0, O_CPE);  // LP ignores fifofull
        add(1, 0, 2'd0, 1, 3'b000, 3'b000, 0, 0, O_FUL);  // CPE with fifofull
        add(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LAF);
        add(1, 0, 2'd0, 0, 3'b000, 3'b000, 1, 0, O_DA);
        // invalid address ignored
        add(1, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_DA);
        add(1, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_DA);
        // addr 0 latched: foreign softreset ignored, own softreset aborts
        add(1, 1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LFD);
        add(1, 1, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_LD);
        add(1, 1, 2'd0, 0, 3'b000, 3'b110, 0, 0, O_LD);
        add(1, 1, 2'd0, 0, 3'b000, 3'b001, 0, 0, O_DA);
        // addr 2 packet, reset while full clears the latched address to 0
        add(1, 1, 2'd2, 0, 3'b100, 3'b000, 0, 0, O_LFD);
        add(1, 1, 2'd2, 0, 3'b000, 3'b000, 0, 0, O_LD);
        add(1, 1, 2'd2, 1, 3'b000, 3'b000, 0, 0, O_FUL);
        add(0, 1, 2'd2, 1, 3'b000, 3'b000, 0, 0, O_DA);
        add(1, 1, 2'd1, 0, 3'b010, 3'b001, 0, 0, O_DA);   // softreset0 now selected
        add(1, 1, 2'd1, 0, 3'b010, 3'b100, 0, 0, O_LFD);  // softreset2 no longer selected
        add(1, 1, 2'd1, 0, 3'b000, 3'b000, 0, 0, O_LD);

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Hand sequence: reset held mid-packet for several cycles
        v = vecs[0];
        for (int i = 0; i < 3; i++) step(v, $sformatf("hold_reset%0d", i));

        // Hand sequence: long wait on addr 1, then softreset1 aborts from WAIT_TILL_EMPTY
        v = vecs[0];
        v.rn = 1; v.pv = 1; v.d = 2'd1; v.ff = 0; v.fe = 3'b101; v.exp = O_WTE;
        step(v, "wait_enter");
        v.d = 2'd2;
        for (int i = 0; i < 5; i++) step(v, $sformatf("wait_hold%0d", i));
        v.sr = 3'b011; v.fe = 3'b111; v.exp = O_DA;
        step(v, "wait_softreset");
        v.sr = 3'b000; v.pv = 0; v.exp = O_DA;
        step(v, "idle_after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
